// File: rtl/ip_atan2_cordic.sv
// Vectoring-mode CORDIC: signed (x,y) in, quadrant+degree angle and magnitude out.
// One micro-rotation per clock through IDLE -> FOLD -> ITER -> GAIN.
module ip_atan2_cordic #(
    parameter int DIN_WD = 14,
    parameter int DEG_WD = 17,
    parameter int ITER   = 16,
    parameter int GUARD  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic signed [DIN_WD-1:0] x_in,
    input  logic signed [DIN_WD-1:0] y_in,
    output logic                     out_vld,
    output logic        [DEG_WD-1:0] theta,
    output logic        [DIN_WD-1:0] mag,
    output logic                     zero_vec
);

    localparam int XW = DIN_WD + 2 + GUARD;
    localparam int ZW = DEG_WD + 1;
    localparam int DW = DEG_WD - 2;
    localparam int CW = $clog2(ITER);
    localparam int PW = XW + 17;

    localparam logic        [15:0]   GAIN_C  = 16'h9B75;
    localparam logic signed [PW-1:0] RND     = PW'(64'd1 << (15 + GUARD));
    localparam logic signed [PW-1:0] MAG_MAX = PW'((64'd1 << (DIN_WD - 1)) - 64'd1);
    localparam logic signed [ZW-1:0] Z_MAX   = ZW'((64'd1 << DW) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_FOLD, S_ITER, S_GAIN} state_t;

    state_t                 state_reg, state_next;
    logic signed [XW-1:0]   x_reg, x_next, y_reg, y_next;
    logic signed [ZW-1:0]   z_reg, z_next;
    logic        [1:0]      quad_reg, quad_next;
    logic                   zero_reg, zero_next;
    logic        [CW-1:0]   cnt_reg, cnt_next;

    logic signed [XW-1:0]   sx, sy;
    logic signed [ZW-1:0]   atan_step;
    logic signed [PW-1:0]   prod, prod_rnd, mag_sh;
    logic        [DIN_WD-1:0] mag_sat;
    logic        [DW-1:0]   deg_sat;

    // atan(2^-i) in angle LSBs, 2^17 per full turn
    function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] i);
        logic signed [ZW-1:0] a;
        case (int'(i))
            0:  a = ZW'(16384);
            1:  a = ZW'(9672);
            2:  a = ZW'(5110);
            3:  a = ZW'(2594);
            4:  a = ZW'(1302);
            5:  a = ZW'(652);
            6:  a = ZW'(326);
            7:  a = ZW'(163);
            8:  a = ZW'(81);
            9:  a = ZW'(41);
            10: a = ZW'(20);
            11: a = ZW'(10);
            12: a = ZW'(5);
            13: a = ZW'(3);
            default: a = ZW'(1);
        endcase
        return a;
    endfunction

    assign sx        = x_reg >>> cnt_reg;
    assign sy        = y_reg >>> cnt_reg;
    assign atan_step = atan_lut(cnt_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_rdy     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) state_next = S_FOLD;
            end
            S_FOLD: state_next = S_ITER;
            S_ITER: if (cnt_reg == CW'(ITER - 1)) state_next = S_GAIN;
            S_GAIN: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        x_next    = x_reg;
        y_next    = y_reg;
        z_next    = z_reg;
        quad_next = quad_reg;
        zero_next = zero_reg;
        cnt_next  = cnt_reg;
        case (state_reg)
            S_IDLE: if (in_vld) begin
                x_next    = {{2{x_in[DIN_WD-1]}}, x_in, {GUARD{1'b0}}};
                y_next    = {{2{y_in[DIN_WD-1]}}, y_in, {GUARD{1'b0}}};
                zero_next = (x_in == '0) && (y_in == '0);
            end
            S_FOLD: begin
                z_next   = '0;
                cnt_next = '0;
                // rotate into x>0, y>=0; the all-zero vector falls through as q0
                if (x_reg > 0 && y_reg >= 0) begin
                    quad_next = 2'd0;
                end else if (x_reg <= 0 && y_reg > 0) begin
                    quad_next = 2'd1;
                    x_next    = y_reg;
                    y_next    = -x_reg;
                end else if (x_reg < 0 && y_reg <= 0) begin
                    quad_next = 2'd2;
                    x_next    = -x_reg;
                    y_next    = -y_reg;
                end else if (x_reg >= 0 && y_reg < 0) begin
                    quad_next = 2'd3;
                    x_next    = -y_reg;
                    y_next    = x_reg;
                end else begin
                    quad_next = 2'd0;
                end
            end
            S_ITER: begin
                if (!y_reg[XW-1]) begin
                    x_next = x_reg + sy;
                    y_next = y_reg - sx;
                    z_next = z_reg + atan_step;
                end else begin
                    x_next = x_reg - sy;
                    y_next = y_reg + sx;
                    z_next = z_reg - atan_step;
                end
                cnt_next = cnt_reg + 1'b1;
            end
            default: ;
        endcase
    end

    // Undo the CORDIC gain and drop the guard bits in one rounded multiply
    always_comb begin
        prod     = x_reg * $signed({1'b0, GAIN_C});
        prod_rnd = prod + RND;
        mag_sh   = prod_rnd >>> (16 + GUARD);
        if (mag_sh > MAG_MAX)  mag_sat = MAG_MAX[DIN_WD-1:0];
        else if (mag_sh < 0)   mag_sat = '0;
        else                   mag_sat = mag_sh[DIN_WD-1:0];
        if (z_reg < 0)         deg_sat = '0;
        else if (z_reg > Z_MAX) deg_sat = Z_MAX[DW-1:0];
        else                   deg_sat = z_reg[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg    <= '0;
            y_reg    <= '0;
            z_reg    <= '0;
            quad_reg <= '0;
            zero_reg <= 1'b0;
            cnt_reg  <= '0;
            out_vld  <= 1'b0;
            theta    <= '0;
            mag      <= '0;
            zero_vec <= 1'b0;
        end else begin
            x_reg    <= x_next;
            y_reg    <= y_next;
            z_reg    <= z_next;
            quad_reg <= quad_next;
            zero_reg <= zero_next;
            cnt_reg  <= cnt_next;
            out_vld  <= (state_reg == S_GAIN);
            if (state_reg == S_GAIN) begin
                theta    <= zero_reg ? '0 : {quad_reg, deg_sat};
                mag      <= zero_reg ? '0 : mag_sat;
                zero_vec <= zero_reg;
            end
        end
    end

endmodule
